ex_muldiv_unit: RTL and testbench

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/div_step.sv | 24 ++
 rtl/ex_muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
//   - funct codes of the HI/LO instruction group
//   - FSM state enum (IDLE / MUL / DIV)
//   - iteration counter width and funct decode helpers
package muldiv_pkg;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {IDLE, MUL, DIV} md_state_e;

  // Any funct this unit responds to; everything else is ignored.
  function automatic logic fn_decoded(input logic [5:0] f);
    return (f inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                      FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
  endfunction

  // Signed variants work on magnitudes and fix the sign at the end.
  function automatic logic fn_signed(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_DIV);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (combinational).
//   rem_i     : shifted partial remainder {rem, next dividend bit}
//   divisor_i : divisor magnitude
//   rem_o     : next partial remainder
//   q_o       : quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] diff;

  // With a nonzero divisor the remainder stays below it, so the sign bit of
  // the W+1 bit difference is a clean "no borrow" test. The zero-divisor
  // result is overridden by the caller.
  assign diff  = rem_i - {1'b0, divisor_i};
  assign q_o   = ~diff[WIDTH];
  assign rem_o = q_o ? diff[WIDTH-1:0] : rem_i[WIDTH-1:0];

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage HI/LO unit: MFHI/MTHI/MFLO/MTLO, iterative MULT(U) and DIV(U).
// Optional feature macro: MULDIV_FAST_MUL_EN -- single-cycle multiply, no
// busy period for MULT/MULTU. Division is always iterative.
//   clk_i, reset_i (async, active high), flush_i, start_i, funct_e6
//   rs_val_e32 / rt_val_e32 : forwarded operands
//   hi_o / lo_o             : architectural HI/LO
//   mf_result_o             : HI for MFHI, LO for MFLO, else 0
//   busy_o                  : registered, high during an iterative op
//   stall_o                 : hold IF/ID/EX while a new HI/LO op waits
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             start_i,
  input  logic [5:0]       funct_e6,
  input  logic [WIDTH-1:0] rs_val_e32,
  input  logic [WIDTH-1:0] rt_val_e32,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] mf_result_o,
  output logic             busy_o,
  output logic             stall_o
);

  md_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               sgn_q;
  logic [2*WIDTH-1:0] work_q;  // MUL: {acc, multiplier}; DIV: {rem, dividend/quotient}

  logic decoded, accept, last;
  assign decoded = fn_decoded(funct_e6);
  assign accept  = start_i & ~flush_i & decoded & (state_q == IDLE);
  assign last    = (cnt_q == CNT_W'(WIDTH - 1));
  assign stall_o = busy_o & start_i & decoded;

  assign mf_result_o = (funct_e6 == FN_MFHI) ? hi_o :
                       (funct_e6 == FN_MFLO) ? lo_o : '0;

  // Magnitudes of the incoming operands (seed the work register).
  logic             in_sgn;
  logic [WIDTH-1:0] in_a_mag, in_b_mag;
  assign in_sgn   = fn_signed(funct_e6);
  assign in_a_mag = (in_sgn & rs_val_e32[WIDTH-1]) ? -rs_val_e32 : rs_val_e32;
  assign in_b_mag = (in_sgn & rt_val_e32[WIDTH-1]) ? -rt_val_e32 : rt_val_e32;

  // Magnitudes and signs of the latched operands.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = sgn_q & a_q[WIDTH-1];
  assign b_neg = sgn_q & b_q[WIDTH-1];
  assign a_mag = a_neg ? -a_q : a_q;
  assign b_mag = b_neg ? -b_q : b_q;

  // Shift-add step: add multiplicand to the upper half when the multiplier
  // LSB is set, then shift the whole product right (carry enters at top).
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, mul_res;
  assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, a_mag} : '0);
  assign mul_next = {mul_sum, work_q[WIDTH-1:1]};
  assign mul_res  = (a_neg ^ b_neg) ? -mul_next : mul_next;

  logic [WIDTH-1:0]   div_rem, quo_res, rem_res;
  logic               div_q;
  logic [2*WIDTH-1:0] div_next;
  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i    ({work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]}),
    .divisor_i(b_mag),
    .rem_o    (div_rem),
    .q_o      (div_q)
  );
  assign div_next = {div_rem, work_q[WIDTH-2:0], div_q};
  assign quo_res  = (a_neg ^ b_neg) ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
  assign rem_res  = a_neg ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MUL_EN
  // Sign/zero-extend to 2W so one unsigned multiply serves both variants.
  logic [2*WIDTH-1:0] fast_a, fast_b, fast_prod;
  assign fast_a    = {{WIDTH{in_sgn & rs_val_e32[WIDTH-1]}}, rs_val_e32};
  assign fast_b    = {{WIDTH{in_sgn & rt_val_e32[WIDTH-1]}}, rt_val_e32};
  assign fast_prod = fast_a * fast_b;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      work_q  <= '0;
      hi_o    <= '0;
      lo_o    <= '0;
      busy_o  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          case (funct_e6)
            FN_MTHI: hi_o <= rs_val_e32;
            FN_MTLO: lo_o <= rs_val_e32;
            FN_MULT, FN_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
              {hi_o, lo_o} <= fast_prod;
`else
              state_q <= MUL;
              busy_o  <= 1'b1;
              cnt_q   <= '0;
              a_q     <= rs_val_e32;
              b_q     <= rt_val_e32;
              sgn_q   <= in_sgn;
              work_q  <= {{WIDTH{1'b0}}, in_b_mag};
`endif
            end
            FN_DIV, FN_DIVU: begin
              state_q <= DIV;
              busy_o  <= 1'b1;
              cnt_q   <= '0;
              a_q     <= rs_val_e32;
              b_q     <= rt_val_e32;
              sgn_q   <= in_sgn;
              work_q  <= {{WIDTH{1'b0}}, in_a_mag};
            end
            default: ;
          endcase
        end
        MUL: begin
          work_q <= mul_next;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last) begin
            {hi_o, lo_o} <= mul_res;
            state_q      <= IDLE;
            busy_o       <= 1'b0;
          end
        end
        DIV: begin
          work_q <= div_next;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last) begin
            // Divide-by-zero returns the raw dividend in HI and all ones in LO.
            if (b_q == '0) begin
              hi_o <= a_q;
              lo_o <= '1;
            end else begin
              hi_o <= rem_res;
              lo_o <= quo_res;
            end
            state_q <= IDLE;
            busy_o  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   funct = '0;
  logic [W-1:0] rs = '0, rt = '0;
  logic [W-1:0] hi, lo, mf;
  logic         busy, stall;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk_i(clk), .reset_i(rst), .flush_i(flush), .start_i(start),
    .funct_e6(funct), .rs_val_e32(rs), .rt_val_e32(rt),
    .hi_o(hi), .lo_o(lo), .mf_result_o(mf), .busy_o(busy), .stall_o(stall)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference model built on native arithmetic, returns {HI, LO}.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [W-1:0] a, b);
    longint sa, sb2;
    int     ia, ib;
    case (f)
      FN_MULTU: return {32'd0, a} * {32'd0, b};
      FN_MULT: begin
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        return 64'(sa * sb2);
      end
      FN_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        ia = $signed(a);
        ib = $signed(b);
        return {32'(ia % ib), 32'(ia / ib)};
      end
    endcase
  endfunction

  task automatic push(input string n, input logic [W-1:0] h, l);
    exp_t e;
    e.name = n; e.hi = h; e.lo = l;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, b);
    @(negedge clk); start = 1'b1; funct = f; rs = a; rt = b;
    @(negedge clk); start = 1'b0; funct = '0;
  endtask

  // Called on busy cycle 1; returns number of busy cycles seen (bounded).
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 40) begin cyc++; @(negedge clk); end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    start = 1'b1; funct = FN_MFHI; #1;
    tests_run += 5;
    if (busy !== 1'b0)  begin tests_failed++; $display("FAIL reset_busy got %0b want 0", busy); end
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got %0b want 0", stall); end
    if (hi !== '0)      begin tests_failed++; $display("FAIL reset_hi got %h want 0", hi); end
    if (lo !== '0)      begin tests_failed++; $display("FAIL reset_lo got %h want 0", lo); end
    if (mf !== '0)      begin tests_failed++; $display("FAIL reset_mf got %h want 0", mf); end
    start = 1'b0; funct = '0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_mthi_mtlo;
    @(negedge clk); start = 1'b1; funct = FN_MTHI; rs = 32'hCAFE_0001;
    @(negedge clk); funct = FN_MTLO; rs = 32'hBEEF_0002;
    tests_run += 2;
    if (hi !== 32'hCAFE_0001) begin tests_failed++; $display("FAIL mthi got %h want cafe0001", hi); end
    if (busy !== 1'b0)        begin tests_failed++; $display("FAIL mthi_busy got %0b want 0", busy); end
    @(negedge clk); funct = FN_MFHI; start = 1'b0; #1;
    tests_run += 2;
    if (lo !== 32'hBEEF_0002) begin tests_failed++; $display("FAIL mtlo got %h want beef0002", lo); end
    if (mf !== 32'hCAFE_0001) begin tests_failed++; $display("FAIL mfhi got %h want cafe0001", mf); end
    funct = FN_MFLO; #1;
    tests_run++;
    if (mf !== 32'hBEEF_0002) begin tests_failed++; $display("FAIL mflo got %h want beef0002", mf); end
    funct = '0;
  endtask

  task automatic test_iter_op(input string n, input logic [5:0] f, input logic [W-1:0] a, b,
                              input logic [W-1:0] eh, el);
    exp_t e;
    int   cyc;
    push(n, eh, el);
    issue(f, a, b);
    wait_idle(cyc);
    e = sb.pop_front();
    tests_run += 3;
    if (cyc !== 32)  begin tests_failed++; $display("FAIL %s_latency got %0d want 32", e.name, cyc); end
    if (hi !== e.hi) begin tests_failed++; $display("FAIL %s_hi got %h want %h", e.name, hi, e.hi); end
    if (lo !== e.lo) begin tests_failed++; $display("FAIL %s_lo got %h want %h", e.name, lo, e.lo); end
  endtask

  task automatic test_spec_vectors;
`ifndef MULDIV_FAST_MUL_EN
    test_iter_op("multu_max", FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    test_iter_op("mult_neg",  FN_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
`endif
    test_iter_op("div_neg",   FN_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    test_iter_op("divu_zero", FN_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
    test_iter_op("div_ovf",   FN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    test_iter_op("div_zero",  FN_DIV,   32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
  endtask

  task automatic test_random;
    logic [5:0]  f;
    logic [W-1:0] a, b;
    logic [63:0] m;
    for (int i = 0; i < 8; i++) begin
`ifdef MULDIV_FAST_MUL_EN
      f = (i % 2 == 0) ? FN_DIV : FN_DIVU;
`else
      case (i % 4)
        0: f = FN_MULT;  1: f = FN_MULTU;
        2: f = FN_DIV;   default: f = FN_DIVU;
      endcase
`endif
      a = $urandom;
      b = (i == 6) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      m = model(f, a, b);
      test_iter_op("rand", f, a, b, m[63:32], m[31:0]);
    end
  endtask

  task automatic test_mf_stall;
    exp_t        e;
    int          bad;
    logic [63:0] m;
    logic [5:0]  f;
`ifdef MULDIV_FAST_MUL_EN
    f = FN_DIVU;
`else
    f = FN_MULTU;
`endif
    m = model(f, 32'h1234_5678, 32'h0009_ABCD);
    push("mf_stall", m[63:32], m[31:0]);
    issue(f, 32'h1234_5678, 32'h0009_ABCD);   // now in busy cycle 1
    repeat (4) @(negedge clk);                  // busy cycle 5
    start = 1'b1; funct = FN_MFLO;
    bad = 0;
    for (int c = 5; c <= 32; c++) begin
      #1; if (stall !== 1'b1) bad++;
      @(negedge clk);
    end
    #1;
    e = sb.pop_front();
    tests_run += 3;
    if (bad !== 0)      begin tests_failed++; $display("FAIL mf_stall_held low_cycles %0d want 0", bad); end
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL mf_stall_release got %0b want 0", stall); end
    if (mf !== e.lo)    begin tests_failed++; $display("FAIL mf_new_lo got %h want %h", mf, e.lo); end
    start = 1'b0; funct = '0;
  endtask

  task automatic test_back_to_back;
    exp_t        e;
    int          cyc;
    logic [63:0] m;
    m = model(FN_DIV, 32'hFFFF_8000, 32'h0000_0123);
    push("b2b_first", m[63:32], m[31:0]);
    issue(FN_DIV, 32'hFFFF_8000, 32'h0000_0123);
    repeat (31) @(negedge clk);                 // busy cycle 32
    start = 1'b1; funct = FN_DIVU; rs = 32'd100; rt = 32'd7; #1;
    tests_run++;
    if (stall !== 1'b1) begin tests_failed++; $display("FAIL b2b_stall_last got %0b want 1", stall); end
    @(negedge clk);
    e = sb.pop_front();
    tests_run += 3;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle got %0b want 0", busy); end
    if (hi !== e.hi)   begin tests_failed++; $display("FAIL b2b_first_hi got %h want %h", hi, e.hi); end
    if (lo !== e.lo)   begin tests_failed++; $display("FAIL b2b_first_lo got %h want %h", lo, e.lo); end
    push("b2b_second", 32'd2, 32'd14);
    @(negedge clk); start = 1'b0; funct = '0;
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_accept got %0b want 1", busy); end
    wait_idle(cyc);
    e = sb.pop_front();
    tests_run += 3;
    if (cyc !== 32)  begin tests_failed++; $display("FAIL b2b_second_latency got %0d want 32", cyc); end
    if (hi !== e.hi) begin tests_failed++; $display("FAIL b2b_second_hi got %h want %h", hi, e.hi); end
    if (lo !== e.lo) begin tests_failed++; $display("FAIL b2b_second_lo got %h want %h", lo, e.lo); end
  endtask

  task automatic test_reset_mid;
    issue(FN_DIV, 32'd1000, 32'd3);             // busy cycle 1
    repeat (9) @(negedge clk);                  // busy cycle 10
    start = 1'b1; funct = FN_MFLO;
    rst = 1'b1; #1;
    tests_run += 5;
    if (busy !== 1'b0)  begin tests_failed++; $display("FAIL rstmid_busy got %0b want 0", busy); end
    if (hi !== '0)      begin tests_failed++; $display("FAIL rstmid_hi got %h want 0", hi); end
    if (lo !== '0)      begin tests_failed++; $display("FAIL rstmid_lo got %h want 0", lo); end
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL rstmid_stall got %0b want 0", stall); end
    if (mf !== '0)      begin tests_failed++; $display("FAIL rstmid_mf got %h want 0", mf); end
    #1; rst = 1'b0; start = 1'b0; funct = '0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_stays_idle got %0b want 0", busy); end
    // A fresh op right after reset must run a full, clean iteration.
    test_iter_op("post_rst", FN_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333);
  endtask

  task automatic test_flush;
    exp_t e;
    int   cyc;
    @(negedge clk); start = 1'b1; funct = FN_MTHI; rs = 32'h0000_AAAA;
    @(negedge clk); funct = FN_MTLO; rs = 32'h0000_5555;
    @(negedge clk); flush = 1'b1; funct = FN_DIVU; rs = 32'd9; rt = 32'd3;
    @(negedge clk); funct = FN_MTHI; rs = 32'h1234_0000;
    tests_run += 3;
    if (busy !== 1'b0)        begin tests_failed++; $display("FAIL flush_div_busy got %0b want 0", busy); end
    if (lo !== 32'h0000_5555) begin tests_failed++; $display("FAIL flush_div_lo got %h want 00005555", lo); end
    if (hi !== 32'h0000_AAAA) begin tests_failed++; $display("FAIL flush_div_hi got %h want 0000aaaa", hi); end
    @(negedge clk); start = 1'b0; flush = 1'b0; funct = '0;
    tests_run++;
    if (hi !== 32'h0000_AAAA) begin tests_failed++; $display("FAIL flush_mthi got %h want 0000aaaa", hi); end
    // Flush during an in-flight op belongs to an older instruction: no abort.
    push("flush_inflight", 32'd5, 32'd7);
    issue(FN_DIVU, 32'd54, 32'd7);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    wait_idle(cyc);
    e = sb.pop_front();
    tests_run += 3;
    if (cyc !== 29)  begin tests_failed++; $display("FAIL flush_inflight_latency got %0d want 29", cyc); end
    if (hi !== e.hi) begin tests_failed++; $display("FAIL flush_inflight_hi got %h want %h", hi, e.hi); end
    if (lo !== e.lo) begin tests_failed++; $display("FAIL flush_inflight_lo got %h want %h", lo, e.lo); end
  endtask

  task automatic test_fast_mul;
`ifdef MULDIV_FAST_MUL_EN
    exp_t e;
    int   busy_seen;
    push("fast_mult", 32'd0, 32'd42);
    push("fast_mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    busy_seen = 0;
    @(negedge clk); start = 1'b1; funct = FN_MULT; rs = 32'd6; rt = 32'd7;
    @(negedge clk); rs = 32'hFFFF_FFFD; rt = 32'd5;
    if (busy) busy_seen++;
    e = sb.pop_front();
    tests_run += 2;
    if (hi !== e.hi) begin tests_failed++; $display("FAIL %s_hi got %h want %h", e.name, hi, e.hi); end
    if (lo !== e.lo) begin tests_failed++; $display("FAIL %s_lo got %h want %h", e.name, lo, e.lo); end
    @(negedge clk); start = 1'b0; funct = '0;
    if (busy) busy_seen++;
    e = sb.pop_front();
    tests_run += 3;
    if (hi !== e.hi)     begin tests_failed++; $display("FAIL %s_hi got %h want %h", e.name, hi, e.hi); end
    if (lo !== e.lo)     begin tests_failed++; $display("FAIL %s_lo got %h want %h", e.name, lo, e.lo); end
    if (busy_seen !== 0) begin tests_failed++; $display("FAIL fast_busy got %0d want 0", busy_seen); end
`else
    test_iter_op("iter_mult", FN_MULT, 32'd6, 32'd7, 32'd0, 32'd42);
`endif
  endtask

  initial begin
    test_reset;
    test_mthi_mtlo;
    test_spec_vectors;
    test_random;
    test_mf_stall;
    test_back_to_back;
    test_reset_mid;
    test_flush;
    test_fast_mul;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
